// File: rtl/cmd_pkt_pkg.sv
// Shared types and constants for the command packet receive path.
package cmd_pkt_pkg;

    typedef enum logic [2:0] {IDLE, HI, LO, CHK, HOLD} pkt_state_t;

    localparam logic [7:0] CHK_TARGET = 8'hFF;
    localparam int         PKT_BYTES  = 4;

    // Modulo-256 sum of all four packet bytes.
    function automatic logic [7:0] pkt_sum(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
        return b0 + b1 + b2 + b3;
    endfunction

endpackage

// File: rtl/pkt_timeout_cnt.sv
// Inter-byte idle counter; expire is high while enabled and the count sits at TO_CYCLES-1.
module pkt_timeout_cnt #(
    parameter int TO_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW   = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TO_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/cmd_pkt_rx.sv
// Frames UART bytes into 4-byte checksummed command packets for cmd_cfg.
// Rejected or stalled packets are dropped, counted and flagged for a NAK.
module cmd_pkt_rx
    import cmd_pkt_pkg::*;
#(
    parameter int TO_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        clr_cmd_rdy,
    output logic        err_resp_req,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    // Handshakes: a byte moves when rx_rdy and clr_rx_rdy are both high at a rising
    // edge; a packet is handed over when cmd_rdy and clr_cmd_rdy are both high at an edge.

    localparam int SHADOW_W = (PKT_BYTES - 1) * 8;

    pkt_state_t          state, state_nxt;
    logic [SHADOW_W-1:0] shadow;
    logic                shift_en, load_cmd, reject;
    logic                in_pkt, expire, sum_ok;

    assign in_pkt     = state inside {HI, LO, CHK};
    assign clr_rx_rdy = rx_rdy && (state inside {IDLE, HI, LO, CHK});
    assign busy       = (state != IDLE);
    assign sum_ok     = (pkt_sum(shadow[23:16], shadow[15:8], shadow[7:0], rx_data) == CHK_TARGET);

    pkt_timeout_cnt #(.TO_CYCLES(TO_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_rx_rdy || !in_pkt),
        .en     (in_pkt),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A byte present on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        load_cmd  = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_rdy) begin
                    shift_en  = 1'b1;
                    state_nxt = HI;
                end
            end
            HI: begin
                if (rx_rdy) begin
                    shift_en  = 1'b1;
                    state_nxt = LO;
                end else if (expire) begin
                    reject    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            LO: begin
                if (rx_rdy) begin
                    shift_en  = 1'b1;
                    state_nxt = CHK;
                end else if (expire) begin
                    reject    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CHK: begin
                if (rx_rdy) begin
                    if (sum_ok) begin
                        load_cmd  = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        reject    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (expire) begin
                    reject    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (clr_cmd_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow       <= '0;
            cmd          <= 8'h00;
            data         <= 16'h0000;
            cmd_rdy      <= 1'b0;
            err_resp_req <= 1'b0;
            err_cnt      <= 8'h00;
        end else begin
            err_resp_req <= reject;
            if (shift_en) begin
                shadow <= {shadow[SHADOW_W-9:0], rx_data};
            end
            if (load_cmd) begin
                cmd     <= shadow[23:16];
                data    <= shadow[15:0];
                cmd_rdy <= 1'b1;
            end else if ((state == HOLD) && clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
            if (reject && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_cmd_pkt_rx.sv
// Directed bench for cmd_pkt_rx: framing, checksum, timeout, back-pressure, reset, saturation.
module tb_cmd_pkt_rx;

    localparam int TO = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic        err_resp_req;
    logic [7:0]  err_cnt;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];

    cmd_pkt_rx #(.TO_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_rdy       (rx_rdy),
        .rx_data      (rx_data),
        .clr_rx_rdy   (clr_rx_rdy),
        .cmd_rdy      (cmd_rdy),
        .cmd          (cmd),
        .data         (data),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .err_resp_req (err_resp_req),
        .err_cnt      (err_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n       = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        #1;
        while (!clr_rx_rdy && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("byte_accept", clr_rx_rdy, 1);
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int gap);
        send_byte(b0);
        repeat (gap) @(negedge clk);
        send_byte(b1);
        repeat (gap) @(negedge clk);
        send_byte(b2);
        repeat (gap) @(negedge clk);
        send_byte(b3);
    endtask

    task automatic expect_pkt();
        logic [23:0] e;
        check("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cmd_rdy", cmd_rdy, 1);
            check("cmd", cmd, e[23:16]);
            check("data", data, e[15:0]);
            check("busy_hold", busy, 1);
        end
    endtask

    task automatic clear_cmd();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("cmd_rdy_cleared", cmd_rdy, 0);
        check("busy_after_clear", busy, 0);
    endtask

    initial begin
        rst         = 1'b1;
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_cmd", cmd, 8'h00);
        check("rst_data", data, 16'h0000);
        check("rst_err_resp", err_resp_req, 0);
        check("rst_err_cnt", err_cnt, 8'h00);
        check("rst_busy", busy, 0);

        // Calibrate packet, back-to-back
        exp_q.push_back({8'h06, 16'h0000});
        send_pkt(8'h06, 8'h00, 8'h00, 8'hF9, 0);
        expect_pkt();
        check("cal_err_cnt", err_cnt, 8'h00);
        clear_cmd();

        // Set pitch with 1000-cycle gaps
        exp_q.push_back({8'h02, 16'hBEEF});
        send_pkt(8'h02, 8'hBE, 8'hEF, 8'h50, 1000);
        expect_pkt();
        clear_cmd();

        // Bad checksum
        send_pkt(8'h03, 8'h1F, 8'h4B, 8'h00, 0);
        check("bad_err_resp", err_resp_req, 1);
        check("bad_err_cnt", err_cnt, 8'h01);
        check("bad_cmd_rdy", cmd_rdy, 0);
        check("bad_cmd_hold", cmd, 8'h02);
        check("bad_data_hold", data, 16'hBEEF);
        check("bad_busy", busy, 0);
        @(negedge clk);
        check("bad_err_resp_1cyc", err_resp_req, 0);

        // Timeout after two bytes
        send_byte(8'h05);
        send_byte(8'h00);
        repeat (TO - 1) @(negedge clk);
        check("to_busy_before", busy, 1);
        check("to_no_err_before", err_resp_req, 0);
        @(negedge clk);
        check("to_err_resp", err_resp_req, 1);
        check("to_err_cnt", err_cnt, 8'h02);
        check("to_busy", busy, 0);
        check("to_cmd_hold", cmd, 8'h02);
        @(negedge clk);
        check("to_err_resp_1cyc", err_resp_req, 0);

        exp_q.push_back({8'h05, 16'h0045});
        send_pkt(8'h05, 8'h00, 8'h45, 8'hB5, 0);
        expect_pkt();

        // HOLD back-pressure: byte 07 waits until the packet is taken
        rx_data = 8'h07;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            check("hold_no_consume", clr_rx_rdy, 0);
            @(negedge clk);
        end
        check("hold_cmd_rdy", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        #1;
        check("hold_exit_cmd_rdy", cmd_rdy, 0);
        check("hold_exit_consume", clr_rx_rdy, 1);
        @(negedge clk);
        rx_rdy = 1'b0;
        check("hold_07_busy", busy, 1);

        // A byte on the expiry cycle beats the timeout
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h00);
        check("edge_no_err", err_resp_req, 0);
        check("edge_busy", busy, 1);
        check("edge_err_cnt", err_cnt, 8'h02);
        exp_q.push_back({8'h07, 16'h0000});
        send_byte(8'h00);
        send_byte(8'hF8);
        expect_pkt();
        clear_cmd();

        // Reset mid-packet
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_cmd_rdy", cmd_rdy, 0);
        check("mid_rst_cmd", cmd, 8'h00);
        check("mid_rst_data", data, 16'h0000);
        check("mid_rst_err_cnt", err_cnt, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err_resp", err_resp_req, 0);
        @(negedge clk);
        check("mid_rst_err_resp_after", err_resp_req, 0);
        check("mid_rst_busy_after", busy, 0);

        // Saturation of the error counter
        for (int i = 0; i < 260; i++) begin
            send_pkt(8'h03, 8'h1F, 8'h4B, 8'h00, 0);
            if (i == 0)   check("sat_first", err_cnt, 8'h01);
            if (i == 253) check("sat_254", err_cnt, 8'hFE);
            if (i == 254) check("sat_255", err_cnt, 8'hFF);
        end
        check("sat_err_resp", err_resp_req, 1);
        check("sat_final", err_cnt, 8'hFF);
        check("sat_cmd_rdy", cmd_rdy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
